// File: rtl/graphics_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : graphics_pkg
//  Purpose  : Shared defaults and FSM state type for the spectrum-display
//             bin bank scheduler.
//  Contents : c_DEFAULT_SAMPLES, c_DEFAULT_WIDTH, state_t {FILL, FULL, SWAP}
//  Revision : 1.0 - initial release
// ============================================================================
package graphics_pkg;

    localparam int c_DEFAULT_SAMPLES = 32;
    localparam int c_DEFAULT_WIDTH   = 32;

    // FILL : writer may deliver beats into the write bank
    // FULL : write bank holds a complete frame, waiting for vblank
    // SWAP : single cycle in which the banks exchange roles
    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        SWAP = 2'd2
    } state_t;

endpackage : graphics_pkg
`default_nettype wire

// File: rtl/bin_bank_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : bin_bank_scheduler_if
//  Purpose  : Writer handshake, vblank strobe and display-side outputs of the
//             bin bank scheduler, bundled as one interface.
//  Modports : master - writer / frame source (drives wr_*, vblank_pulse)
//             slave  - scheduler (drives wr_ready and all display outputs)
//  Revision : 1.0 - initial release
// ============================================================================
interface bin_bank_scheduler_if
    import graphics_pkg::*;
#(
    parameter int SAMPLES = c_DEFAULT_SAMPLES,
    parameter int WIDTH   = c_DEFAULT_WIDTH
);
    logic                            wr_valid;
    logic [WIDTH-1:0]                wr_data;
    logic                            wr_last;
    logic                            wr_ready;
    logic                            vblank_pulse;
    logic [SAMPLES-1:0][WIDTH-1:0]   frequency_bins;
    logic                            whichRAM;
    logic                            swap_done;
    logic                            frame_error;
    logic [15:0]                     swap_count;

    modport master (
        output wr_valid, wr_data, wr_last, vblank_pulse,
        input  wr_ready, frequency_bins, whichRAM, swap_done, frame_error, swap_count
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, vblank_pulse,
        output wr_ready, frequency_bins, whichRAM, swap_done, frame_error, swap_count
    );
endinterface : bin_bank_scheduler_if
`default_nettype wire

// File: rtl/bin_bank.sv
`default_nettype none
// ============================================================================
//  Module   : bin_bank
//  Purpose  : One frame of bins: SAMPLES x WIDTH register array with a single
//             write port, full parallel read and synchronous clear.
//  Ports    : clk, rst          - clock / synchronous active-high clear
//             i_wr_en, i_wr_idx, i_wr_data - write port
//             o_rd_data         - every entry, in parallel
//  Revision : 1.0 - initial release
// ============================================================================
module bin_bank #(
    parameter int SAMPLES = 32,
    parameter int WIDTH   = 32,
    parameter int IDX_W   = 5
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          i_wr_en,
    input  wire logic [IDX_W-1:0]              i_wr_idx,
    input  wire logic [WIDTH-1:0]              i_wr_data,
    output      logic [SAMPLES-1:0][WIDTH-1:0] o_rd_data
);

    logic [SAMPLES-1:0][WIDTH-1:0] r_mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '0;
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem;

endmodule : bin_bank
`default_nettype wire

// File: rtl/bin_bank_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : bin_bank_scheduler
//  Purpose  : Double-buffered frequency-bin store. A writer fills the hidden
//             bank; once a full frame is held, the banks swap on the next
//             vblank strobe so the display never sees a partial frame.
//  Ports    : clk   - single rising-edge clock
//             reset - synchronous active-high reset
//             bus   - bin_bank_scheduler_if.slave (writer handshake, vblank,
//                     frequency_bins, whichRAM, swap_done, frame_error,
//                     swap_count)
//  Revision : 1.0 - initial release
// ============================================================================
module bin_bank_scheduler
    import graphics_pkg::*;
#(
    parameter int SAMPLES = c_DEFAULT_SAMPLES,
    parameter int WIDTH   = c_DEFAULT_WIDTH
) (
    input  wire logic           clk,
    input  wire logic           reset,
    bin_bank_scheduler_if.slave bus
);

    localparam int                 c_IDX_W    = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(SAMPLES - 1);

    state_t                        r_state;
    state_t                        w_next_state;
    logic [c_IDX_W-1:0]            r_wr_idx;
    logic                          r_which;
    logic                          r_swap_done;
    logic                          r_frame_error;
    logic [15:0]                   r_swap_count;

    logic                          w_accept;
    logic                          w_at_end;
    logic [SAMPLES-1:0][WIDTH-1:0] w_bank_rd [2];

    assign w_accept = bus.wr_valid && (r_state == FILL);
    assign w_at_end = (r_wr_idx == c_LAST_IDX);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            FILL:    if (w_accept && w_at_end) w_next_state = FULL;
            // vblank only matters once a whole frame is held; a vblank that
            // coincides with the completing beat is seen while still in FILL.
            FULL:    if (bus.vblank_pulse)     w_next_state = SWAP;
            SWAP:                              w_next_state = FILL;
            default:                           w_next_state = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= FILL;
            r_wr_idx      <= '0;
            r_which       <= 1'b0;
            r_swap_done   <= 1'b0;
            r_frame_error <= 1'b0;
            r_swap_count  <= '0;
        end else begin
            r_state     <= w_next_state;
            // Registered on entry to SWAP so the pulse spans the SWAP cycle.
            r_swap_done <= (r_state == FULL) && bus.vblank_pulse;
            // Malformed when the last marker and the final slot disagree:
            // early wr_last (frame dropped) or missing wr_last (frame kept).
            r_frame_error <= w_accept && (w_at_end != bus.wr_last);

            if (w_accept) begin
                r_wr_idx <= (w_at_end || bus.wr_last) ? '0 : r_wr_idx + 1'b1;
            end

            if (r_state == SWAP) begin
                r_which <= ~r_which;
                if (r_swap_count != 16'hFFFF) begin
                    r_swap_count <= r_swap_count + 16'd1;
                end
            end
        end
    end

    // Only the bank not on display is ever written.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        bin_bank #(
            .SAMPLES (SAMPLES),
            .WIDTH   (WIDTH),
            .IDX_W   (c_IDX_W)
        ) u_bank (
            .clk       (clk),
            .rst       (reset),
            .i_wr_en   (w_accept && (r_which != 1'(b))),
            .i_wr_idx  (r_wr_idx),
            .i_wr_data (bus.wr_data),
            .o_rd_data (w_bank_rd[b])
        );
    end

    assign bus.wr_ready       = (r_state == FILL);
    assign bus.frequency_bins = r_which ? w_bank_rd[1] : w_bank_rd[0];
    assign bus.whichRAM       = r_which;
    assign bus.swap_done      = r_swap_done;
    assign bus.frame_error    = r_frame_error;
    assign bus.swap_count     = r_swap_count;

endmodule : bin_bank_scheduler
`default_nettype wire

// File: tb/tb_bin_bank_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin_bank_scheduler
//  Purpose  : Self-checking bench for bin_bank_scheduler. A frame-level
//             reference model (two bank arrays, frame position, pending /
//             swapping flags) predicts every output each cycle for directed
//             scenarios followed by randomized traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bin_bank_scheduler;
    import graphics_pkg::*;

    localparam int c_S = 32;
    localparam int c_W = 32;

    logic clk = 1'b0;
    logic reset;

    bin_bank_scheduler_if #(.SAMPLES(c_S), .WIDTH(c_W)) bus ();

    bin_bank_scheduler #(.SAMPLES(c_S), .WIDTH(c_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: frame-level view of the scheduler
    logic [c_S-1:0][c_W-1:0] m_bank [2];
    int                      m_disp;
    int                      m_pos;
    bit                      m_pending;
    bit                      m_swapping;
    int                      m_count;
    bit                      m_sd;
    bit                      m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %0s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit v, input logic [c_W-1:0] d, input bit l,
                              input bit vb, input bit rs);
        m_sd  = 0;
        m_err = 0;
        if (rs) begin
            m_bank[0] = '0; m_bank[1] = '0;
            m_disp = 0; m_pos = 0; m_pending = 0; m_swapping = 0; m_count = 0;
        end else if (m_swapping) begin
            m_disp     = 1 - m_disp;
            m_count    = (m_count < 65535) ? m_count + 1 : 65535;
            m_swapping = 0;
        end else if (m_pending) begin
            if (vb) begin
                m_pending  = 0;
                m_swapping = 1;
                m_sd       = 1;
            end
        end else if (v) begin
            m_bank[1 - m_disp][m_pos] = d;
            if (m_pos == c_S - 1) begin
                m_pending = 1;
                m_pos     = 0;
                m_err     = !l;
            end else if (l) begin
                m_pos = 0;
                m_err = 1;
            end else begin
                m_pos++;
            end
        end
    endtask

    // One clock: drive, step the model at the edge, compare #1 later.
    task automatic cycle(input bit v, input logic [c_W-1:0] d, input bit l,
                         input bit vb, input bit rs);
        bus.wr_valid     = v;
        bus.wr_data      = d;
        bus.wr_last      = l;
        bus.vblank_pulse = vb;
        reset            = rs;
        @(posedge clk);
        model_edge(v, d, l, vb, rs);
        #1;
        check("wr_ready",    32'(bus.wr_ready),    32'(!m_pending && !m_swapping));
        check("whichRAM",    32'(bus.whichRAM),    32'(m_disp));
        check("swap_done",   32'(bus.swap_done),   32'(m_sd));
        check("frame_error", 32'(bus.frame_error), 32'(m_err));
        check("swap_count",  32'(bus.swap_count),  32'(m_count));
        n_vec++;
        assert (bus.frequency_bins === m_bank[m_disp]) else begin
            n_err++;
            $error("FAIL frequency_bins: observed bin0=%0h bin31=%0h expected bin0=%0h bin31=%0h",
                   bus.frequency_bins[0], bus.frequency_bins[c_S-1],
                   m_bank[m_disp][0], m_bank[m_disp][c_S-1]);
        end
    endtask

    task automatic frame(input int n, input int last_at, input bit vb_on_last, input int base);
        for (int i = 0; i < n; i++)
            cycle(1'b1, 32'(base + i), (i == last_at), vb_on_last && (i == n - 1), 1'b0);
    endtask

    task automatic idle(input int n, input bit vb_at_end);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 32'hDEAD_BEEF, 1'b0, vb_at_end && (i == n - 1), 1'b0);
    endtask

    initial begin
        m_bank[0] = '0; m_bank[1] = '0;
        m_disp = 0; m_pos = 0; m_pending = 0; m_swapping = 0; m_count = 0;

        // Reset state
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("rst_ready", 32'(bus.wr_ready), 32'd1);
        check("rst_bins0", bus.frequency_bins[0], 32'd0);

        // Clean frame data=i, then vblank -> one swap
        frame(c_S, c_S - 1, 1'b0, 0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        check("f1_which", 32'(bus.whichRAM), 32'd1);
        check("f1_count", 32'(bus.swap_count), 32'd1);
        check("f1_bin5",  bus.frequency_bins[5], 32'd5);
        check("f1_bin31", bus.frequency_bins[31], 32'd31);

        // Full frame held for 100 cycles with no vblank, then vblank
        frame(c_S, c_S - 1, 1'b0, 32'h100);
        idle(100, 1'b0);
        check("hold_ready", 32'(bus.wr_ready), 32'd0);
        idle(1, 1'b1);
        idle(2, 1'b0);
        check("hold_which", 32'(bus.whichRAM), 32'd0);

        // Early wr_last on beat 10: dropped, vblank ignored, then clean frame
        frame(11, 10, 1'b0, 32'h200);
        idle(3, 1'b1);
        check("early_count", 32'(bus.swap_count), 32'd2);
        frame(c_S, c_S - 1, 1'b0, 32'h300);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // No wr_last at all: error on beat 31, frame still swaps
        frame(c_S, -1, 1'b0, 32'h400);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Final beat coincident with vblank: swap waits for the next vblank
        frame(c_S, c_S - 1, 1'b1, 32'h500);
        idle(4, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Reset after beat 20, then a clean frame lands in bank 1
        frame(21, -1, 1'b0, 32'h600);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("midrst_which", 32'(bus.whichRAM), 32'd0);
        check("midrst_count", 32'(bus.swap_count), 32'd0);
        frame(c_S, c_S - 1, 1'b0, 32'h700);
        idle(1, 1'b1);
        idle(2, 1'b0);
        check("post_which", 32'(bus.whichRAM), 32'd1);
        check("post_count", 32'(bus.swap_count), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit v, l, vb, rs;
            v  = ($urandom_range(0, 9) < 7);
            l  = (m_pos == c_S - 1) ? ($urandom_range(0, 3) != 0)
                                    : ($urandom_range(0, 59) == 0);
            vb = ($urandom_range(0, 11) == 0);
            rs = ($urandom_range(0, 499) == 0);
            cycle(v, 32'($urandom), l, vb, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bin_bank_scheduler
`default_nettype wire

// File: doc/bin_bank_scheduler.md
BIN_BANK_SCHEDULER -- requirements
Module: bin_bank_scheduler

Interface
REQ-001 SHALL have parameter SAMPLES, default 32, number of frequency bins per frame.
REQ-002 SHALL have parameter WIDTH, default 32, bits per bin.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port wr_valid, input, 1: writer presents a bin.
REQ-006 SHALL have port wr_data, input, WIDTH: bin value.
REQ-007 SHALL have port wr_last, input, 1: writer marks final bin of the frame.
REQ-008 SHALL have port wr_ready, output, 1: scheduler accepts a bin.
REQ-009 SHALL have port vblank_pulse, input, 1: one-cycle display frame-boundary strobe.
REQ-010 SHALL have port frequency_bins, output, WIDTH x SAMPLES array: contents of the display bank.
REQ-011 SHALL have port whichRAM, output, 1: index of the display bank; the writer fills bank !whichRAM.
REQ-012 SHALL have port swap_done, output, 1: one-cycle pulse on a bank swap.
REQ-013 SHALL have port frame_error, output, 1: one-cycle pulse on a malformed frame.
REQ-014 SHALL have port swap_count, output, 16: saturating count of swaps.

Function
REQ-015 SHALL hold two banks of SAMPLES x WIDTH registers; a beat is accepted when wr_valid && wr_ready.
REQ-016 SHALL use FSM states FILL, FULL and SWAP; wr_ready is 1 only in FILL.
REQ-017 In FILL, each accepted beat SHALL write wr_data to write-bank entry wr_idx; wr_idx increments by 1 (width $clog2(SAMPLES)).
REQ-018 An accepted beat at wr_idx == SAMPLES-1 SHALL move FILL->FULL and clear wr_idx to 0; if wr_last==0 on that beat, frame_error SHALL pulse and the frame is still kept.
REQ-019 An accepted beat with wr_last==1 and wr_idx < SAMPLES-1 SHALL pulse frame_error, clear wr_idx to 0, stay in FILL and discard the frame; entries already written stay in the write bank and are later overwritten.
REQ-020 In FULL, vblank_pulse==1 SHALL move FULL->SWAP; with no pulse the FSM stays in FULL.
REQ-021 vblank_pulse in FILL or SWAP SHALL be ignored; the completing beat and a vblank in the same cycle SHALL NOT swap, and the swap waits for the next vblank.
REQ-022 SWAP SHALL last exactly one cycle: toggle whichRAM, pulse swap_done, increment swap_count (hold at 16'hFFFF), then return to FILL.
REQ-023 frequency_bins SHALL be a combinational select of bank whichRAM; it changes only in the cycle after SWAP.
REQ-024 The display bank SHALL never be written.
REQ-025 Latency from the final accepted beat to swap_done SHALL be at least 2 cycles (FULL then SWAP), and 2 cycles when vblank_pulse arrives in the first FULL cycle.

Reset
REQ-026 While reset==1 at a clock edge, the block SHALL set state=FILL, wr_idx=0, whichRAM=0, swap_done=0, frame_error=0, swap_count=0, and both banks to all zeros.
REQ-027 After reset, wr_ready SHALL read 1 and frequency_bins SHALL read all zeros.
REQ-028 Reset mid-frame or in FULL SHALL discard the pending frame and suppress any swap.

Structure
REQ-029 A shared package graphics_pkg SHALL hold the SAMPLES and WIDTH defaults and the FSM state enum (FILL, FULL, SWAP).
REQ-030 Each bank SHALL be one instance of sub-module bin_bank (register array with one write port, full parallel read, synchronous clear); it is instantiated twice.

Verification
REQ-031 Reset, then 32 beats of data=i with wr_last on i=31, then vblank -> swap_done once, whichRAM=1, frequency_bins[k]=k, swap_count=1.
REQ-032 Fill completes and no vblank for 100 cycles -> wr_ready=0 and whichRAM unchanged throughout; next vblank -> swap within 1 cycle.
REQ-033 wr_last on beat 10 -> frame_error pulse, no swap on the next vblank; a following clean 32-beat frame swaps normally.
REQ-034 32 beats with no wr_last -> frame_error pulses on beat 31; frame is kept and swaps on the next vblank.
REQ-035 Final beat coincident with vblank -> no swap that cycle; the swap occurs on the following vblank.
REQ-036 Reset asserted after beat 20 -> all outputs at reset values; the next clean frame lands in bank 1 with swap_count=1.
